// File: rtl/seq_mult_div.sv
// Sequential signed multiply/divide unit.
// One shift-add (multiply) or restoring subtract (divide) step per cycle on
// operand magnitudes, followed by a single sign-correction cycle.
// The busy/done outputs are registered, so they trail the internal state by
// one cycle: busy rises on the edge after the start is accepted, and done
// pulses for one cycle once the DONE state has been left.
module seq_mult_div #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sel,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] ans,
  output logic           div_zero,
  output logic           ovf
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST   = CW'(n - 1);
  localparam logic [n-1:0]  MINMAG = {1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0]  ONE    = n'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]  r_count;
  logic           r_sel;
  logic           r_signA;
  logic           r_signB;
  logic [n-1:0]   r_magA;
  logic [n-1:0]   r_magB;
  logic [2*n-1:0] r_acc;
  logic [2*n-1:0] r_mcand;
  logic [n-1:0]   r_quo;
  logic [n-1:0]   r_rem;
  logic [2*n-1:0] r_ans;
  logic           r_busy;
  logic           r_done;
  logic           r_divZero;
  logic           r_ovf;

  logic [n-1:0]   w_magA;
  logic [n-1:0]   w_magB;
  logic [2*n-1:0] w_accNext;
  logic [n:0]     w_shift;
  logic [n-1:0]   w_diff;
  logic           w_fits;
  logic [2*n-1:0] w_prod;
  logic [n-1:0]   w_quoS;
  logic [n-1:0]   w_remS;
  logic [n-1:0]   w_aBack;
  logic [2*n-1:0] w_fixAns;

  assign w_magA = a[n-1] ? (-a) : a;
  assign w_magB = b[n-1] ? (-b) : b;

  // Multiply step: add the shifted multiplicand when the current multiplier bit is set.
  assign w_accNext = r_acc + (r_quo[0] ? r_mcand : '0);

  // Divide step: bring in the next dividend bit and try subtracting the divisor.
  assign w_shift = {r_rem, r_quo[n-1]};
  assign w_fits  = (w_shift >= {1'b0, r_magB});
  assign w_diff  = w_shift[n-1:0] - r_magB;

  // Sign correction applied in FIX; divide-by-zero returns the dividend as remainder.
  assign w_prod  = (r_signA ^ r_signB) ? (-r_acc) : r_acc;
  assign w_quoS  = (r_signA ^ r_signB) ? (-r_quo) : r_quo;
  assign w_remS  = r_signA ? (-r_rem) : r_rem;
  assign w_aBack = r_signA ? (-r_magA) : r_magA;

  // Select the final signed result for the FIX cycle.
  always_comb begin
    w_fixAns = {w_remS, w_quoS};
    if (r_sel) begin
      w_fixAns = w_prod;
    end else if (r_magB == '0) begin
      w_fixAns = {w_aBack, {n{1'b0}}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> CALC (n cycles) -> FIX -> DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_count == LAST) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath, result/flag registers and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_sel     <= 1'b0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_magA    <= '0;
      r_magB    <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_ans     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_busy <= (r_state == CALC) || (r_state == FIX);
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sel     <= sel;
            r_signA   <= a[n-1];
            r_signB   <= b[n-1];
            r_magA    <= w_magA;
            r_magB    <= w_magB;
            r_count   <= '0;
            r_divZero <= 1'b0;
            r_ovf     <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= {{n{1'b0}}, w_magA};
            r_quo     <= sel ? w_magB : w_magA;
            r_rem     <= '0;
          end
        end
        CALC: begin
          r_count <= r_count + 1'b1;
          if (r_sel) begin
            r_acc   <= w_accNext;
            r_mcand <= r_mcand << 1;
            r_quo   <= r_quo >> 1;
          end else if (w_fits) begin
            r_rem <= w_diff;
            r_quo <= {r_quo[n-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[n-1:0];
            r_quo <= {r_quo[n-2:0], 1'b0};
          end
        end
        FIX: begin
          r_ans     <= w_fixAns;
          r_divZero <= !r_sel && (r_magB == '0);
          r_ovf     <= !r_sel && r_signA && r_signB &&
                       (r_magA == MINMAG) && (r_magB == ONE);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ans      = r_ans;
  assign div_zero = r_divZero;
  assign ovf      = r_ovf;

endmodule

// File: doc/seq_mult_div.md
Name: seq_mult_div

Overview:
- Sequential signed multiply/divide unit; iterative general-operand counterpart to the fixed ×2 / ÷2 scaling block in the ALU datapath.
- Takes two n-bit signed operands: produces a 2n-bit product (sel=1) or an n-bit quotient plus n-bit remainder (sel=0).
- Uses one add/subtract step per cycle with a start/done handshake, so it can sit beside the combinational ALU slices without widening the critical path.

Parameters:
- n, 4, operand width in bits (n ≥ 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sel  input  1  operation select: 1 = multiply, 0 = divide; captured with start.
- a  input  n  signed multiplicand/dividend; captured with start.
- b  input  n  signed multiplier/divisor; captured with start.
- busy  output  1  high from the edge after start acceptance until the DONE state.
- done  output  1  one-cycle pulse; ans and flags are valid while high and held afterwards.
- ans  output  2n  signed result: multiply = full product; divide = {remainder[n-1:0], quotient[n-1:0]}.
- div_zero  output  1  set when a divide had b == 0.
- ovf  output  1  set when a divide had a == −2^(n−1) and b == −1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, ans=0, div_zero=0, ovf=0; iteration counter=0. Takes effect immediately, including mid-operation; the result is discarded.
- States:
  - IDLE: start=1 at an edge captures a, b, sel; records operand signs and magnitudes; clears div_zero and ovf; counter=0. Next state is CALC, busy=1.
  - CALC: one iteration per cycle for exactly n cycles, counter 0..n−1.
  - FIX: one cycle for sign correction and ans write.
  - DONE: one cycle with done=1, busy=0, then back to IDLE.
- Latency: start edge E0 → done high during the cycle after edge E(n+2). Back-to-back start is accepted in the cycle after DONE.
- Multiply: unsigned shift-add on magnitudes. Product sign = sign(a) XOR sign(b). ans is the exact 2n-bit two's-complement product; no overflow is possible.
- Divide: restoring division on magnitudes. Quotient truncates toward zero. The remainder takes the dividend's sign and satisfies a = q·b + r with |r| < |b|. Example: −7/2 → q=−3, r=−1.
- Divide by zero (b=0): CALC still runs n cycles so latency is unchanged. Result: div_zero=1, quotient=0, remainder=a.
- Overflow (a=−2^(n−1), b=−1): ovf=1, quotient=−2^(n−1) (wrapped), remainder=0.
- Magnitude of −2^(n−1) needs n bits unsigned; internal magnitudes are n bits unsigned so this value is handled.
- start while busy or in DONE is ignored; input changes after capture have no effect.
- sel, a, b are don't-care outside the capture edge.
- ans and flags hold their values from FIX until the next accepted start, which clears the flags only. ans updates only in FIX.

Test Plan:
- n=4, sel=1, a=3, b=−2 (4'hE), pulse start → done exactly 6 cycles after the start edge; ans=8'hFA (−6), div_zero=0, ovf=0.
- sel=0, a=−7 (4'h9), b=2 → ans=8'hFD (rem −1=4'hF, quot −3=4'hD); then a=7, b=−2 → ans=8'h1D (rem 1, quot −3).
- sel=0, a=5, b=0 → div_zero=1, ans=8'h50, same 6-cycle latency; next valid op clears div_zero.
- sel=0, a=−8 (4'h8), b=−1 (4'hF) → ovf=1, ans=8'h08; sel=1, a=−8, b=−8 → ans=8'h40 (64), ovf=0.
- Start a multiply; pulse start with new operands and toggle a/b on cycles 2–4 → ignored, original result delivered; start in the cycle after done → accepted.
- Assert rst_n=0 on cycle 3 of CALC → busy, done, ans, and flags are 0 immediately (asynchronously). After release, a new op a=2, b=3, sel=1 → ans=8'h06.
